// File: rtl/static_pkg.sv
// static_pkg: shared types and helpers for the static byte-stream path.
// Holds bit_count (byte popcount), size helpers and the tx FSM state type.
package static_pkg;

  localparam int WORD_SIZE_DEF = 256;

  function automatic int byte_cnt_f(input int ws);
    return ws / 8;
  endfunction

  function automatic int ones_w_f(input int ws);
    return $clog2(ws + 1);
  endfunction

  localparam int BYTE_CNT_DEF = byte_cnt_f(WORD_SIZE_DEF);
  localparam int ONES_W_DEF   = ones_w_f(WORD_SIZE_DEF);

  typedef enum logic {
    IDLE,
    SEND
  } tx_state_t;

  function automatic logic [3:0] bit_count(
    input logic [7:0] b
  );
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, b[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/static_popcnt.sv
// static_popcnt: combinational popcount of a WORD_SIZE-bit word.
// Ports: word_i (word), ones_o (count, $clog2(WORD_SIZE+1) bits).
module static_popcnt
  import static_pkg::*;
#(
  parameter int WORD_SIZE = 256
) (
  input  logic [WORD_SIZE-1:0]         word_i,
  output logic [$clog2(WORD_SIZE+1)-1:0] ones_o
);

  localparam int ONES_W = ones_w_f(WORD_SIZE);
  localparam int NB     = byte_cnt_f(WORD_SIZE);
  localparam int LEVELS = $clog2(NB);
  localparam int NP     = 1 << LEVELS;

  // Binary adder tree; leaves past NB are zero padding.
  for (genvar l = 0; l <= LEVELS; l++) begin : lvl_g
    localparam int N = NP >> l;
    logic [ONES_W-1:0] sum [N];
    if (l == 0) begin : leaf_g
      for (genvar i = 0; i < N; i++) begin : b_g
        if (i < NB) begin : real_g
          assign sum[i] = ONES_W'(bit_count(word_i[8*i +: 8]));
        end else begin : pad_g
          assign sum[i] = '0;
        end
      end
    end else begin : node_g
      for (genvar i = 0; i < N; i++) begin : n_g
        assign sum[i] = lvl_g[l-1].sum[2*i]
                      + lvl_g[l-1].sum[2*i+1];
      end
    end
  end

  assign ones_o = lvl_g[LEVELS].sum[0];

endmodule

// File: rtl/static_tx.sv
// static_tx: serialises WORD_SIZE-bit words to a byte stream, byte 0 first.
// In: clk, rst, word_data/word_valid, out_ready. Out: word_ready, out_data,
// out_valid, out_sof, out_eof, word_ones, busy.
// STATIC_TX_TRAILER_EN adds an XOR trailer byte that carries eof.
module static_tx
  import static_pkg::*;
#(
  parameter int WORD_SIZE = 256
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [WORD_SIZE-1:0]           word_data,
  input  logic                           word_valid,
  output logic                           word_ready,
  output logic [7:0]                     out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_sof,
  output logic                           out_eof,
  output logic [$clog2(WORD_SIZE+1)-1:0] word_ones,
  output logic                           busy
);

  localparam int BYTE_CNT = byte_cnt_f(WORD_SIZE);
  localparam int ONES_W   = ones_w_f(WORD_SIZE);
`ifdef STATIC_TX_TRAILER_EN
  localparam int FRAME_LEN = BYTE_CNT + 1;
`else
  localparam int FRAME_LEN = BYTE_CNT;
`endif
  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(FRAME_LEN - 1);

  tx_state_t             state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [WORD_SIZE-1:0]  word_q, word_d;
  logic [ONES_W-1:0]     ones_q, ones_d;
  logic [ONES_W-1:0]     pop_ones;
  logic [7:0]            byte_sel;
  logic                  last;
  logic                  accept;

  static_popcnt #(
    .WORD_SIZE (WORD_SIZE)
  ) u_popcnt (
    .word_i (word_data),
    .ones_o (pop_ones)
  );

`ifdef STATIC_TX_TRAILER_EN
  logic [7:0] xor_q, xor_d, xor_in;

  always_comb begin
    xor_in = '0;
    for (int i = 0; i < BYTE_CNT; i++) begin
      xor_in = xor_in ^ word_data[8*i +: 8];
    end
  end
`endif

  assign last = (idx_q == LAST_IDX);

  always_comb begin
    byte_sel = '0;
    for (int i = 0; i < BYTE_CNT; i++) begin
      if (idx_q == IDX_W'(i)) begin
        byte_sel = word_q[8*i +: 8];
      end
    end
`ifdef STATIC_TX_TRAILER_EN
    if (last) begin
      byte_sel = xor_q;
    end
`endif
  end

  assign out_valid = (state_q == SEND);
  assign busy      = out_valid;
  assign out_data  = out_valid ? byte_sel : 8'h00;
  assign out_sof   = out_valid && (idx_q == '0);
  assign out_eof   = out_valid && last;
  assign word_ones = ones_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    word_d     = word_q;
    ones_d     = ones_q;
`ifdef STATIC_TX_TRAILER_EN
    xor_d      = xor_q;
`endif
    word_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        word_ready = !rst;
      end
      SEND: begin
        if (out_ready) begin
          if (last) begin
            // Reopen intake only as the eof byte leaves.
            word_ready = 1'b1;
            state_d    = IDLE;
            idx_d      = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    accept = word_valid && word_ready;
    if (accept) begin
      state_d = SEND;
      idx_d   = '0;
      word_d  = word_data;
      ones_d  = pop_ones;
`ifdef STATIC_TX_TRAILER_EN
      xor_d   = xor_in;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      word_q  <= '0;
      ones_q  <= '0;
`ifdef STATIC_TX_TRAILER_EN
      xor_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      ones_q  <= ones_d;
`ifdef STATIC_TX_TRAILER_EN
      xor_q   <= xor_d;
`endif
    end
  end

endmodule
